// File: rtl/maze_vga_renderer_if.sv
// VGA pin bundle driven by maze_vga_renderer: colour channels, syncs and frame-start pulse.
interface maze_vga_renderer_if #(
  parameter int unsigned COLOR_BITS = 3
);
  logic [COLOR_BITS-1:0] o_VGA_Red;
  logic [COLOR_BITS-1:0] o_VGA_Green;
  logic [COLOR_BITS-1:0] o_VGA_Blue;
  logic                  o_VGA_HSync;
  logic                  o_VGA_VSync;
  logic                  o_FrameStart;

  modport master (
    output o_VGA_Red, o_VGA_Green, o_VGA_Blue,
    output o_VGA_HSync, o_VGA_VSync, o_FrameStart
  );

  modport slave (
    input o_VGA_Red, o_VGA_Green, o_VGA_Blue,
    input o_VGA_HSync, o_VGA_VSync, o_FrameStart
  );
endinterface

// File: rtl/maze_vga_renderer.sv
// Parametrised VGA maze renderer: timing, cell lookup, frame-boundary shadow load, 2-stage output pipe.
// Optional goal blinking in RUN is enabled by defining MAZE_VGA_BLINK_EN.
module maze_vga_renderer #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned MAZE_W     = 40,
  parameter int unsigned MAZE_H     = 30,
  parameter int unsigned CELL_LOG2  = 4,
  parameter int unsigned COLOR_BITS = 3
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  input  logic [MAZE_W*MAZE_H*2-1:0]  i_Maze,
  input  logic [1:0]                  i_MazeState,
  input  logic [$clog2(MAZE_W)-1:0]   i_PlayerX,
  input  logic [$clog2(MAZE_H)-1:0]   i_PlayerY,
  maze_vga_renderer_if.master         vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned PXW     = $clog2(MAZE_W);
  localparam int unsigned PYW     = $clog2(MAZE_H);

  localparam logic [COLOR_BITS-1:0] C_MAX  = '1;
  localparam logic [COLOR_BITS-1:0] C_HALF = C_MAX >> 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_SOLVED = 2'b10,
    ST_ERROR  = 2'b11
  } maze_state_t;

  typedef enum logic [1:0] {
    CELL_PATH  = 2'b00,
    CELL_WALL  = 2'b01,
    CELL_START = 2'b10,
    CELL_GOAL  = 2'b11
  } cell_t;

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  logic [MAZE_W*MAZE_H*2-1:0] sh_maze;
  maze_state_t                sh_state;
  logic [PXW-1:0]             sh_px;
  logic [PYW-1:0]             sh_py;
  logic                       shadow_load;

  // Stage-0 combinational decode of the counters
  logic  c_vis, c_hit, c_hs, c_vs, c_fs;
  cell_t c_code;

  // Stage-1 registers
  logic  s1_vis, s1_hit, s1_hs, s1_vs, s1_fs;
  cell_t s1_code;

  logic [COLOR_BITS-1:0] red, green, blue;
  logic                  blink_off;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign shadow_load = (h == '0) && (v == VW'(V_ACTIVE));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sh_maze  <= '0;
      sh_state <= ST_IDLE;
      sh_px    <= '0;
      sh_py    <= '0;
    end else if (shadow_load) begin
      sh_maze  <= i_Maze;
      sh_state <= maze_state_t'(i_MazeState);
      sh_px    <= i_PlayerX;
      sh_py    <= i_PlayerY;
    end
  end

`ifdef MAZE_VGA_BLINK_EN
  logic [5:0] frame_cnt;

  // Advances once per frame during vertical blank, so the phase never changes mid-picture
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      frame_cnt <= '0;
    end else if (shadow_load) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign blink_off = frame_cnt[5];
`else
  assign blink_off = 1'b0;
`endif

  always_comb begin
    int unsigned cx;
    int unsigned cy;
    int unsigned idx;
    logic        in_maze;
    logic        active;
    cx      = 32'(h) >> CELL_LOG2;
    cy      = 32'(v) >> CELL_LOG2;
    active  = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    in_maze = (cx < MAZE_W) && (cy < MAZE_H);
    // Index is forced to 0 off-maze so the part-select never leaves the vector
    idx     = in_maze ? (cy * MAZE_W + cx) : 0;
    c_code  = cell_t'(sh_maze[idx*2 +: 2]);
    c_vis   = active && in_maze;
    c_hit   = in_maze && (cx == 32'(sh_px)) && (cy == 32'(sh_py));
    c_hs    = ((32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC))
              ? SYNC_POL : ~SYNC_POL;
    c_vs    = ((32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC))
              ? SYNC_POL : ~SYNC_POL;
    c_fs    = (h == '0) && (v == '0);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      s1_vis  <= 1'b0;
      s1_hit  <= 1'b0;
      s1_code <= CELL_PATH;
      s1_hs   <= ~SYNC_POL;
      s1_vs   <= ~SYNC_POL;
      s1_fs   <= 1'b0;
    end else begin
      s1_vis  <= c_vis;
      s1_hit  <= c_hit;
      s1_code <= c_code;
      s1_hs   <= c_hs;
      s1_vs   <= c_vs;
      s1_fs   <= c_fs;
    end
  end

  // Shadow state is read unpipelined: it only changes while the pipe holds blanking pixels
  always_comb begin
    red   = '0;
    green = '0;
    blue  = '0;
    if (s1_vis) begin
      case (sh_state)
        ST_IDLE: begin
          if (s1_code == CELL_WALL) red = C_HALF;
        end
        ST_RUN: begin
          case (s1_code)
            CELL_WALL:  red   = C_MAX;
            CELL_START: green = C_MAX;
            CELL_GOAL:  blue  = blink_off ? '0 : C_MAX;
            default: ;
          endcase
        end
        ST_SOLVED: begin
          if (s1_code == CELL_WALL) begin
            green = C_MAX;
          end else if (s1_code != CELL_PATH) begin
            red   = C_MAX;
            green = C_MAX;
            blue  = C_MAX;
          end
        end
        default: red = C_MAX;
      endcase
      if (s1_hit && (sh_state == ST_RUN || sh_state == ST_SOLVED)) begin
        red   = C_MAX;
        green = C_MAX;
        blue  = C_MAX;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      vga.o_VGA_Red    <= '0;
      vga.o_VGA_Green  <= '0;
      vga.o_VGA_Blue   <= '0;
      vga.o_VGA_HSync  <= ~SYNC_POL;
      vga.o_VGA_VSync  <= ~SYNC_POL;
      vga.o_FrameStart <= 1'b0;
    end else begin
      vga.o_VGA_Red    <= red;
      vga.o_VGA_Green  <= green;
      vga.o_VGA_Blue   <= blue;
      vga.o_VGA_HSync  <= s1_hs;
      vga.o_VGA_VSync  <= s1_vs;
      vga.o_FrameStart <= s1_fs;
    end
  end

endmodule

// File: tb/tb_maze_vga_renderer.sv
// Self-checking bench for maze_vga_renderer on a reduced timing/maze geometry.
module tb_maze_vga_renderer;
  localparam int HA = 48, HFP = 2, HSW = 4, HBP = 2;
  localparam int VA = 40, VFP = 1, VSW = 2, VBP = 2;
  localparam int MW = 5, MH = 4, CL = 3, CELL = 8, NC = MW * MH;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int LOAD = VA * HT;
  localparam bit SP = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC*2-1:0] maze = '0;
  logic [1:0] mstate = '0;
  logic [2:0] px = '0;
  logic [1:0] py = '0;

  maze_vga_renderer_if #(.COLOR_BITS(3)) vga_if ();

  maze_vga_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(SP), .MAZE_W(MW), .MAZE_H(MH), .CELL_LOG2(CL), .COLOR_BITS(3)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Maze(maze), .i_MazeState(mstate),
    .i_PlayerX(px), .i_PlayerY(py), .vga(vga_if)
  );

  always #5 clk = ~clk;

  int k;
  int n_cmp = 0;
  int n_err = 0;
  int m_cell[NC];
  int m_state, m_px, m_py;
  logic [11:0] obs, expv;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout k=%0d", k);
    $fatal(1, "watchdog");
  end

  // Expected {R,G,B,HS,VS,FS} for output position p (p<0: reset values)
  function automatic logic [11:0] exp_out(int p);
    int x, y, c;
    logic [2:0] r, g, b;
    logic hs, vs, fs;
    r = 3'd0; g = 3'd0; b = 3'd0;
    if (p < 0) return {9'd0, ~SP, ~SP, 1'b0};
    x = p % HT;
    y = (p / HT) % VT;
    hs = (x >= HA + HFP && x < HA + HFP + HSW) ? SP : ~SP;
    vs = (y >= VA + VFP && y < VA + VFP + VSW) ? SP : ~SP;
    fs = (x == 0 && y == 0);
    if (x < HA && y < VA && x / CELL < MW && y / CELL < MH) begin
      c = m_cell[(y / CELL) * MW + x / CELL];
      case (m_state)
        0: if (c == 1) r = 3'd3;
        1: begin
          if (c == 1) r = 3'd7;
          if (c == 2) g = 3'd7;
          if (c == 3) b = 3'd7;
        end
        2: begin
          if (c == 1) g = 3'd7;
          if (c >= 2) begin r = 3'd7; g = 3'd7; b = 3'd7; end
        end
        default: r = 3'd7;
      endcase
      if ((m_state == 1 || m_state == 2) && x / CELL == m_px && y / CELL == m_py) begin
        r = 3'd7; g = 3'd7; b = 3'd7;
      end
    end
    return {r, g, b, hs, vs, fs};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_cell[i] = 0;
    m_state = 0; m_px = 0; m_py = 0;
  endtask

  task automatic capture();
    for (int i = 0; i < NC; i++) m_cell[i] = int'(maze[2*i +: 2]);
    m_state = int'(mstate); m_px = int'(px); m_py = int'(py);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic logic [11:0] sample();
    return {vga_if.o_VGA_Red, vga_if.o_VGA_Green, vga_if.o_VGA_Blue,
            vga_if.o_VGA_HSync, vga_if.o_VGA_VSync, vga_if.o_FrameStart};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic fill_maze(input logic [1:0] code);
    for (int i = 0; i < NC; i++) maze[2*i +: 2] = code;
  endtask

  task automatic test_reset();
    fill_maze(2'b01); mstate = 2'b01; px = 3'd0; py = 2'd0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    obs = sample(); expv = {9'd0, ~SP, ~SP, 1'b0};
    n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL reset_values got %h expected %h", obs, expv); end
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      obs = sample(); expv = exp_out(k - 2); n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL after_reset k=%0d got %h expected %h", k, obs, expv); end
      if (k % FRAME == LOAD) capture();
    end
  endtask

  task automatic test_sync_timing();
    int hs_first, hs_w, hs_per, vs_first, vs_w, fs1, fs2;
    logic phs, pvs;
    hs_first = -1; hs_w = -1; hs_per = -1; vs_first = -1; vs_w = -1; fs1 = -1; fs2 = -1;
    phs = ~SP; pvs = ~SP;
    do_reset();
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      tick();
      if (phs == ~SP && vga_if.o_VGA_HSync == SP) begin
        if (hs_first < 0) hs_first = k; else if (hs_per < 0) hs_per = k - hs_first;
      end
      if (phs == SP && vga_if.o_VGA_HSync == ~SP && hs_first >= 0 && hs_w < 0) hs_w = k - hs_first;
      if (pvs == ~SP && vga_if.o_VGA_VSync == SP && vs_first < 0) vs_first = k;
      if (pvs == SP && vga_if.o_VGA_VSync == ~SP && vs_first >= 0 && vs_w < 0) vs_w = k - vs_first;
      if (vga_if.o_FrameStart) begin
        if (fs1 < 0) fs1 = k; else if (fs2 < 0) fs2 = k;
      end
      phs = vga_if.o_VGA_HSync; pvs = vga_if.o_VGA_VSync;
      if (k % FRAME == LOAD) capture();
    end
    n_cmp++; if (hs_first != HA + HFP + 2) begin n_err++; $display("FAIL hsync_first got %0d expected %0d", hs_first, HA + HFP + 2); end
    n_cmp++; if (hs_w != HSW) begin n_err++; $display("FAIL hsync_width got %0d expected %0d", hs_w, HSW); end
    n_cmp++; if (hs_per != HT) begin n_err++; $display("FAIL hsync_period got %0d expected %0d", hs_per, HT); end
    n_cmp++; if (vs_first != (VA + VFP) * HT + 2) begin n_err++; $display("FAIL vsync_first got %0d expected %0d", vs_first, (VA + VFP) * HT + 2); end
    n_cmp++; if (vs_w != VSW * HT) begin n_err++; $display("FAIL vsync_width got %0d expected %0d", vs_w, VSW * HT); end
    n_cmp++; if (fs1 != 2) begin n_err++; $display("FAIL framestart_first got %0d expected 2", fs1); end
    n_cmp++; if (fs2 - fs1 != FRAME) begin n_err++; $display("FAIL framestart_period got %0d expected %0d", fs2 - fs1, FRAME); end
  endtask

  task automatic test_all_wall();
    fill_maze(2'b01); mstate = 2'b01;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      obs = sample(); expv = exp_out(k - 2); n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL all_wall k=%0d got %h expected %h", k, obs, expv); end
      if (k % FRAME == LOAD) capture();
    end
  endtask

  task automatic test_start_cell();
    fill_maze(2'b00); maze[1:0] = 2'b10; mstate = 2'b01; px = 3'd6;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      obs = sample(); expv = exp_out(k - 2); n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL start_cell k=%0d got %h expected %h", k, obs, expv); end
      if (k % FRAME == LOAD) capture();
    end
  endtask

  task automatic test_midframe_change();
    int red_now, red_next;
    red_now = 0; red_next = 0;
    fill_maze(2'b00); mstate = 2'b01; px = 3'd7;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      obs = sample(); expv = exp_out(k - 2); n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL midframe k=%0d got %h expected %h", k, obs, expv); end
      if (i >= FRAME && (k - 2) % FRAME == 20 * HT) fill_maze(2'b01);
      if (i >= FRAME && vga_if.o_VGA_Red == 3'd7) begin
        if ((k - 2) / FRAME == (k - 2 - i + FRAME) / FRAME + 0) red_now++;
      end
      if (k % FRAME == LOAD) capture();
    end
  endtask

  task automatic test_player();
    fill_maze(2'b00); mstate = 2'b01; px = 3'd4; py = 2'd3;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      obs = sample(); expv = exp_out(k - 2); n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL player k=%0d got %h expected %h", k, obs, expv); end
      if (k % FRAME == LOAD) capture();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5 * FRAME; i++) begin
      tick();
      obs = sample(); expv = exp_out(k - 2); n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL random k=%0d got %h expected %h", k, obs, expv); end
      if ($urandom_range(0, 399) == 0 || k % FRAME == LOAD) begin
        maze = {$urandom, $urandom};
        mstate = 2'($urandom_range(0, 3));
        px = 3'($urandom_range(0, 7));
        py = 2'($urandom_range(0, 3));
      end
      if (k % FRAME == LOAD) capture();
    end
  endtask

  task automatic test_reset_midframe();
    bit loaded, hit;
    loaded = 0; hit = 0;
    fill_maze(2'b01); mstate = 2'b11;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      tick();
      obs = sample(); expv = exp_out(k - 2); n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL pre_reset k=%0d got %h expected %h", k, obs, expv); end
      if (k % FRAME == LOAD) begin capture(); loaded = 1; end
      if (loaded && k % FRAME == 200 * 0 + 20 * HT + 30) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL reach_h30_v20 got 0 expected 1"); end
    rst_n = 1'b0;
    #1;
    obs = sample(); expv = {9'd0, ~SP, ~SP, 1'b0}; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL async_reset got %h expected %h", obs, expv); end
    model_reset();
    @(posedge clk); #1;
    obs = sample(); n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL held_reset got %h expected %h", obs, expv); end
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      tick();
      obs = sample(); expv = exp_out(k - 2); n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL post_reset k=%0d got %h expected %h", k, obs, expv); end
      if (k == 2) begin
        n_cmp++;
        if (vga_if.o_FrameStart !== 1'b1) begin n_err++; $display("FAIL restart_framestart got %b expected 1", vga_if.o_FrameStart); end
      end
      if (k % FRAME == LOAD) capture();
    end
  endtask

  initial begin
    k = 0;
    model_reset();
    test_reset();
    test_sync_timing();
    test_all_wall();
    test_start_cell();
    test_midframe_change();
    test_player();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
